// File: rtl/alu_pkg.sv
// alu_pkg: constants and types shared by the issue stage and the ALU.
//   - ALU op codes (4 bits). Codes 10-15 are unused.
//   - RV32I major opcodes handled by the integer issue stage.
//   - funct7 values that select the base and alternate operations.
//   - issue_t: the payload carried from decode to the ALU.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int ALU_W  = 4;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // Field order is the packed order inside the skid buffer (75 bits).
    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [ALU_W-1:0]  alu_control;
        logic [4:0]        rd;
        logic              rd_we;
        logic              illegal;
    } issue_t;

    localparam int ISSUE_W = $bits(issue_t);

    // funct3 -> op code. 000 always yields ADD here; SUB is an OP-only
    // override applied by the caller. alt (instr[30]) picks SRA over SRL.
    function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_issue_skid.sv
// alu_issue_skid: generic 2-entry skid buffer (main/output register + skid).
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   upstream handshake; in_ready is registered
//   in_data [W]         upstream payload
//   out_valid/out_ready downstream handshake
//   out_data [W]        downstream payload (held stable while stalled)
module alu_issue_skid #(
    parameter int W = 75
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_valid, skid_valid, ready_q;
    logic [W-1:0] main_data, skid_data;
    logic         main_valid_d, skid_valid_d;
    logic [W-1:0] main_data_d, skid_data_d;
    logic         accept, drain;

    assign accept = in_valid & ready_q;
    assign drain  = main_valid & out_ready;

    // ready_q is low whenever skid holds data, so accept and a skid
    // refill can never coincide.
    always_comb begin
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        main_data_d  = main_data;
        skid_data_d  = skid_data;
        if (drain) begin
            if (skid_valid) begin
                main_data_d  = skid_data;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_data_d  = in_data;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid) begin
                main_data_d  = in_data;
                main_valid_d = 1'b1;
            end else begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            main_data  <= main_data_d;
            skid_data  <= skid_data_d;
            ready_q    <= !skid_valid_d;
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I integer decode/issue stage feeding the ALU.
// Decodes OP / OP-IMM / LUI / AUIPC into operands A/B and a 4-bit ALU op,
// then registers the result through a 2-entry skid buffer (1 cycle latency,
// 1 instr/cycle). Undecodable instructions are still issued, flagged illegal.
//   clk, rst                    clock, synchronous active-high reset
//   in_valid/in_ready           upstream handshake
//   in_instr, in_pc             instruction word and its address
//   in_rs1_data, in_rs2_data    register operands
//   out_valid/out_ready         downstream handshake
//   out_a, out_b                ALU operands
//   out_alu_control             ALU op code
//   out_rd, out_rd_we           destination register and write enable
//   out_illegal                 instruction not handled by this stage
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_data,
    input  logic [31:0] in_rs2_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [3:0]  out_alu_control,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic        out_illegal
);

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_u, shamt;
    logic        legal;
    issue_t      dec, out_q;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_u  = {in_instr[31:12], 12'b0};
    assign shamt  = {27'b0, in_instr[24:20]};

    always_comb begin
        dec    = '0;
        legal  = 1'b0;
        dec.rd = in_instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.a           = in_rs1_data;
                dec.b           = in_rs2_data;
                dec.alu_control = f3_to_alu(funct3, in_instr[30]);
                if (funct7 == F7_BASE) begin
                    legal = 1'b1;
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    legal = 1'b1;
                    if (funct3 == 3'b000) dec.alu_control = ALU_SUB;
                end
            end
            OPC_OP_IMM: begin
                dec.a           = in_rs1_data;
                dec.b           = imm_i;
                dec.alu_control = f3_to_alu(funct3, in_instr[30]);
                legal           = 1'b1;
                // Shifts carry shamt in the immediate; upper bits must be a
                // recognised funct7 or the encoding is reserved.
                if (funct3 == 3'b001) begin
                    dec.b = shamt;
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec.b = shamt;
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end
            end
            OPC_LUI: begin
                dec.b = imm_u;
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                dec.a = in_pc;
                dec.b = imm_u;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.a           = '0;
            dec.b           = '0;
            dec.alu_control = ALU_ADD;
            dec.illegal     = 1'b1;
        end
        dec.rd_we = legal && (in_instr[11:7] != 5'd0);
    end

    alu_issue_skid #(.W(ISSUE_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (dec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_q)
    );

    assign out_a           = out_q.a;
    assign out_b           = out_q.b;
    assign out_alu_control = out_q.alu_control;
    assign out_rd          = out_q.rd;
    assign out_rd_we       = out_q.rd_we;
    assign out_illegal     = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed cases with literal expectations, then
// randomized traffic checked every cycle against a queue-based model.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, in_rs1_data, in_rs2_data, out_a, out_b;
    logic [3:0]  out_alu_control;
    logic [4:0]  out_rd;
    logic        out_rd_we, out_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_alu_control(out_alu_control),
        .out_rd(out_rd), .out_rd_we(out_rd_we), .out_illegal(out_illegal)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the RV32I field rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [3:0] tbl [8];
        bit         ok;
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        opc = ins[6:0];
        f7  = ins[31:25];
        f3  = ins[14:12];
        e   = '0;
        e.rd = ins[11:7];
        ok  = 0;
        case (opc)
            7'h33: begin
                e.a = r1; e.b = r2; e.ctl = tbl[f3];
                if (f7 == 7'h00) ok = 1;
                else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1; e.ctl = 4'd1; end
                else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1; e.ctl = 4'd9; end
            end
            7'h13: begin
                e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.ctl = tbl[f3]; ok = 1;
                if (f3 == 3'd1) begin e.b = {27'd0, ins[24:20]}; ok = (f7 == 7'h00); end
                if (f3 == 3'd5) begin
                    e.b = {27'd0, ins[24:20]};
                    ok  = (f7 == 7'h00) || (f7 == 7'h20);
                    if (f7 == 7'h20) e.ctl = 4'd9;
                end
            end
            7'h37: begin e.b = {ins[31:12], 12'h000}; ok = 1; end
            7'h17: begin e.a = pc; e.b = {ins[31:12], 12'h000}; ok = 1; end
            default: ok = 0;
        endcase
        if (!ok) begin e.a = '0; e.b = '0; e.ctl = 4'd0; e.ill = 1'b1; end
        e.we = ok && (ins[11:7] != 5'd0);
        return e;
    endfunction

    // Compare process: outputs are checked at the negedge, then the model
    // is advanced by the handshakes that the coming posedge will perform.
    logic rst_q = 1'b1;
    always @(posedge clk) rst_q <= rst;

    logic        prev_stall = 1'b0;
    logic [31:0] h_a, h_b;
    logic [3:0]  h_ctl;

    always @(negedge clk) begin
        if (rst_q) begin
            chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
            chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_out_a", out_a, 32'd0);
            chk("rst_out_b", out_b, 32'd0);
        end else begin
            chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
            chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
            if (q.size() > 0) begin
                chk("a", out_a, q[0].a);
                chk("b", out_b, q[0].b);
                chk("alu_control", {28'd0, out_alu_control}, {28'd0, q[0].ctl});
                chk("rd", {27'd0, out_rd}, {27'd0, q[0].rd});
                chk("rd_we", {31'd0, out_rd_we}, {31'd0, q[0].we});
                chk("illegal", {31'd0, out_illegal}, {31'd0, q[0].ill});
            end
            if (prev_stall) begin
                chk("stall_a", out_a, h_a);
                chk("stall_b", out_b, h_b);
                chk("stall_ctl", {28'd0, out_alu_control}, {28'd0, h_ctl});
            end
        end
        prev_stall = !rst && !rst_q && out_valid && !out_ready;
        h_a = out_a; h_b = out_b; h_ctl = out_alu_control;
        if (rst) begin
            q.delete();
        end else if (!rst_q) begin
            logic can_take;
            can_take = q.size() < 2;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && can_take) q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one instruction and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
        for (int i = 0; i < 50; i++) begin
            acc = in_ready;
            tick();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    localparam logic [31:0] I_ADD   = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_SUB   = {7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    localparam logic [31:0] I_SRAI  = {7'b0100000, 5'd3, 5'd1, 3'b101, 5'd4, 7'b0010011};
    localparam logic [31:0] I_LUI   = {20'h12345, 5'd5, 7'b0110111};
    localparam logic [31:0] I_AUIPC = {20'h00001, 5'd6, 7'b0010111};
    localparam logic [31:0] I_LOAD  = {12'h000, 5'd1, 3'b010, 5'd7, 7'b0000011};
    localparam logic [31:0] I_BADF7 = {7'b0000001, 5'd2, 5'd1, 3'b000, 5'd8, 7'b0110011};

    initial begin
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;

        // Model pinned against hand-derived values.
        e = model(I_SRAI, 32'h0, 32'h80000000, 32'h0);
        chk("model_srai_ctl", {28'd0, e.ctl}, 32'd9);
        chk("model_srai_b", e.b, 32'd3);
        e = model(32'hFFF0_8093, 32'h0, 32'd10, 32'd0); // addi x1,x1,-1
        chk("model_addi_b", e.b, 32'hFFFF_FFFF);
        e = model(I_BADF7, 32'h0, 32'd1, 32'd2);
        chk("model_badf7_ill", {31'd0, e.ill}, 32'd1);

        repeat (3) tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Directed decode checks, ALU side always ready.
        out_ready = 1'b1;
        send(I_ADD, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        chk("add_valid", {31'd0, out_valid}, 32'd1);
        chk("add_a", out_a, 32'd5);
        chk("add_b", out_b, 32'd7);
        chk("add_ctl", {28'd0, out_alu_control}, 32'd0);
        chk("add_rd", {27'd0, out_rd}, 32'd3);
        chk("add_we", {31'd0, out_rd_we}, 32'd1);
        tick();
        send(I_SUB, 32'h0, 32'd9, 32'd4);
        @(negedge clk);
        chk("sub_ctl", {28'd0, out_alu_control}, 32'd1);
        tick();
        send(I_SRAI, 32'h0, 32'h80000000, 32'd0);
        @(negedge clk);
        chk("srai_ctl", {28'd0, out_alu_control}, 32'd9);
        chk("srai_a", out_a, 32'h80000000);
        chk("srai_b", out_b, 32'd3);
        tick();
        send(I_LUI, 32'h0, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        chk("lui_a", out_a, 32'd0);
        chk("lui_b", out_b, 32'h12345000);
        chk("lui_ctl", {28'd0, out_alu_control}, 32'd0);
        tick();
        send(I_AUIPC, 32'h100, 32'h0, 32'h0);
        @(negedge clk);
        chk("auipc_a", out_a, 32'h100);
        chk("auipc_b", out_b, 32'h1000);
        tick();
        send(I_LOAD, 32'h0, 32'h11, 32'h22);
        @(negedge clk);
        chk("load_valid", {31'd0, out_valid}, 32'd1);
        chk("load_ill", {31'd0, out_illegal}, 32'd1);
        chk("load_a", out_a, 32'd0);
        chk("load_we", {31'd0, out_rd_we}, 32'd0);
        tick();
        send(I_BADF7, 32'h0, 32'h11, 32'h22);
        @(negedge clk);
        chk("badf7_ill", {31'd0, out_illegal}, 32'd1);
        chk("badf7_b", out_b, 32'd0);
        chk("badf7_we", {31'd0, out_rd_we}, 32'd0);
        tick();

        // Back-pressure: 4 instructions, ALU stalled for the first 3 cycles.
        begin
            int  sent, cyc;
            bit  seen;
            logic acc;
            sent = 0; cyc = 0; seen = 0;
            out_ready = 1'b0;
            in_valid = 1'b1; in_instr = I_ADD; in_rs1_data = 32'd100; in_rs2_data = 32'd0;
            while (sent < 4 && cyc < 40) begin
                acc = in_ready;
                if (sent == 2 && !seen) begin
                    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
                    seen = 1;
                end
                tick();
                cyc++;
                out_ready = (cyc >= 3);
                if (acc) begin
                    sent++;
                    in_rs1_data = 32'd100 + sent;
                end
            end
            in_valid = 1'b0;
            chk("bp_all_sent", sent, 32'd4);
            out_ready = 1'b1;
            for (int i = 0; i < 20 && q.size() != 0; i++) tick();
            chk("bp_drained", q.size(), 32'd0);
        end

        // Reset with both entries occupied.
        out_ready = 1'b0;
        send(I_ADD, 32'h0, 32'd1, 32'd2);
        send(I_SUB, 32'h0, 32'd3, 32'd4);
        @(negedge clk);
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();

        // Randomized traffic, rare resets.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] ins;
            int          k;
            ins = $urandom;
            k   = $urandom_range(0, 5);
            case (k)
                0: ins[6:0] = 7'b0110011;
                1: ins[6:0] = 7'b0010011;
                2: ins[6:0] = 7'b0110111;
                3: ins[6:0] = 7'b0010111;
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) ins[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            in_instr    = ins;
            in_pc       = $urandom;
            in_rs1_data = $urandom;
            in_rs2_data = $urandom;
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            rst         = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Registered decode/issue stage that turns a 32-bit RV32I integer instruction plus its register operands into the operand pair and 4-bit ALU op code consumed by the CPU's combinational ALU. It sits between register-file read and the ALU, encodes the ALU control field, and isolates the two sides with a valid/ready handshake and a 2-entry skid buffer. The stage sustains one instruction per cycle and has one cycle of latency.

## Interface
- No parameters. Data width is fixed at 32, op code width at 4.
- clk  in  1  single clock. Reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction and operands present.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  32  instruction address.
- in_rs1_data  in  32  value of rs1.
- in_rs2_data  in  32  value of rs2.
- out_valid  out  1  issued op present.
- out_ready  in  1  ALU side accepts.
- out_a  out  32  ALU operand A.
- out_b  out  32  ALU operand B.
- out_alu_control  out  4  ALU op code.
- out_rd  out  5  destination register.
- out_rd_we  out  1  write-back enable.
- out_illegal  out  1  instruction not decodable by this stage.

## Operation
- ALU op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLT=5, SLTU=6, SLL=7, SRL=8, SRA=9. Codes 10–15 are never emitted.
- funct3 mapping:
  - 000 → ADD, or SUB only for OP with funct7=0100000.
  - 001 → SLL.
  - 010 → SLT.
  - 011 → SLTU.
  - 100 → XOR.
  - 101 → SRL when instr[30]=0, SRA when instr[30]=1.
  - 110 → OR.
  - 111 → AND.
- OP (0110011): a=rs1, b=rs2.
- OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20]. For shifts, b={27'b0, instr[24:20]}.
- LUI (0110111): a=0, b={instr[31:12],12'b0}, ADD.
- AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, ADD.
- out_rd=instr[11:7]. out_rd_we=1 for legal instructions with rd≠0.
- Illegal cases:
  - Any other opcode.
  - OP with funct7 ∉ {0000000, 0100000}.
  - OP with funct7=0100000 and funct3 ∉ {000, 101}.
  - OP-IMM funct3=001 with instr[31:25]≠0.
  - OP-IMM funct3=101 with instr[31:25] ∉ {0000000, 0100000}.
- Illegal response: out_illegal=1, alu_control=ADD, a=b=0, rd_we=0. The entry is still issued through the handshake, not dropped.

## Timing
- Reset: out_valid=0, in_ready=0 during reset and 1 from the first cycle after reset. All data outputs are 0.
- An input transfers when in_valid&in_ready. An output transfers when out_valid&out_ready.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, i.e. valid in cycle N+1.
- Storage is a main (output) register plus a skid register. in_ready is registered and equals !skid_valid, with no combinational path from out_ready.
- Main register empty, or draining this cycle: the accepted entry loads directly into main.
- Main register full and stalled (out_valid & !out_ready) while an input is accepted: the entry goes to skid, and in_ready drops the next cycle.
- Skid drain: when main drains and skid is full, skid moves to main and in_ready returns the next cycle.
- Simultaneous accept and drain with skid empty: the new entry replaces main, giving throughput of 1/cycle.
- Outputs stay stable while out_valid & !out_ready. A stall never corrupts or reorders entries.
- rst asserted mid-stream discards both entries at the next edge, whatever the handshake is doing.

## Structure
- Shared package alu_pkg holds:
  - the ten ALU op-code constants;
  - opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - funct7 constants F7_BASE=0000000 and F7_ALT=0100000.
  The ALU must use the same constants.
- Decode is combinational logic inside alu_issue_stage.
- Buffering lives in one sub-module, alu_issue_skid: a generic 2-entry skid buffer, payload width 32+32+4+5+1+1=75.

## Test plan
- add x3,x1,x2 with rs1=5, rs2=7, out_ready=1: one cycle later out_a=5, out_b=7, alu_control=0, rd=3, rd_we=1.
- sub with funct7=0100000, then srai x4,x1,3 with rs1=0x80000000: alu_control=1; then alu_control=9 with b=3.
- lui x5,0x12345 → a=0, b=0x12345000, ADD. auipc with pc=0x100, imm 1 → a=0x100, b=0x1000.
- Illegal opcode 0000011, and OP with funct7=0000001 → each issued with out_illegal=1, a=b=0, rd_we=0. No instruction is lost.
- Back-pressure: stream 4 instructions with out_ready held 0 for 3 cycles → in_ready falls after the second accept, outputs stay stable, and all 4 emerge in order once out_ready=1.
- Assert rst with both entries full → out_valid=0 next cycle, in_ready=1 the cycle after rst deasserts.
